seq_shift_add_multiplier: RTL and testbench



---
 rtl/seq_shift_add_multiplier_if.sv | 24 ++
 rtl/seq_shift_add_multiplier.sv | 107 ++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// rtl/seq_shift_add_multiplier_if.sv - operand/result handshake bundle for the shift-add multiplier
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic               busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_product, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - iterative radix-2 shift-add multiplier, signed/unsigned per transaction
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  seq_shift_add_multiplier_if.slave bus
);
  localparam int                 PW       = 2 * WIDTH;
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [PW-1:0]      ONE_P    = PW'(1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   ONE_C    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;
  logic             a_is_neg;
  logic             b_is_neg;

  always_comb begin
    state_d   = state_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    a_is_neg  = bus.in_signed & bus.in_a[WIDTH-1];
    b_is_neg  = bus.in_signed & bus.in_b[WIDTH-1];

    // Single adder: the multiplicand is shifted into place by the iteration count.
    addend    = mag_b_q[0] ? (PW'(mag_a_q) << cnt_q) : '0;
    acc_next  = acc_q + addend;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // The most-negative value's magnitude still fits in WIDTH unsigned bits.
          mag_a_d = a_is_neg ? (~bus.in_a + ONE_W) : bus.in_a;
          mag_b_d = b_is_neg ? (~bus.in_b + ONE_W) : bus.in_b;
          neg_d   = a_is_neg ^ b_is_neg;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = acc_next;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + ONE_C;
        if (cnt_q == LAST_CNT) begin
          product_d = neg_q ? (~acc_next + ONE_P) : acc_next;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_product = product_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - scoreboard bench for the shift-add multiplier at WIDTH 8 and 16
module tb_seq_shift_add_multiplier;
  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] prod;
    int          acc_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  seq_shift_add_multiplier_if #(.WIDTH(8))  b8();
  seq_shift_add_multiplier_if #(.WIDTH(16)) b16();

  seq_shift_add_multiplier #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  seq_shift_add_multiplier #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: interpret operands per mode, multiply as integers, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input longint a, input longint b, input int w, input bit s);
    longint x, y, p, mask;
    x = a;
    y = b;
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    p    = x * y;
    mask = (longint'(1) << (2 * w)) - 1;
    return 64'(p & mask);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int w, input logic [31:0] a, input logic [31:0] b, input bit s, input bit push);
    int n;
    logic rdy;
    n   = 0;
    rdy = (w == 8) ? b8.in_ready : b16.in_ready;
    while (!rdy && n < 200) begin
      step();
      rdy = (w == 8) ? b8.in_ready : b16.in_ready;
      n++;
    end
    chk("accept_wait_in_ready", 64'(rdy), 64'd1);
    if (w == 8) begin
      b8.in_a = a[7:0]; b8.in_b = b[7:0]; b8.in_signed = s; b8.in_valid = 1'b1;
    end else begin
      b16.in_a = a[15:0]; b16.in_b = b[15:0]; b16.in_signed = s; b16.in_valid = 1'b1;
    end
    step();
    if (w == 8) begin
      b8.in_valid = 1'b0; b8.in_a = 8'($urandom); b8.in_b = 8'($urandom); b8.in_signed = 1'($urandom);
      if (push) q8.push_back('{prod: ref_mul(longint'(a[7:0]), longint'(b[7:0]), 8, s), acc_cyc: cyc});
    end else begin
      b16.in_valid = 1'b0; b16.in_a = 16'($urandom); b16.in_b = 16'($urandom); b16.in_signed = 1'($urandom);
      if (push) q16.push_back('{prod: ref_mul(longint'(a[15:0]), longint'(b[15:0]), 16, s), acc_cyc: cyc});
    end
  endtask

  bit          prev_v8, idle_chk8;
  logic [63:0] last8;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v8   = 1'b0;
      idle_chk8 = 1'b0;
    end else begin
      if (idle_chk8) begin
        chk("w8_in_ready_after_handshake", 64'(b8.in_ready), 64'd1);
        chk("w8_product_held", 64'(b8.out_product), last8);
        idle_chk8 = 1'b0;
      end
      if (b8.out_valid && !prev_v8) begin
        if (q8.size() == 0) chk("w8_unexpected_out_valid", 64'(b8.out_valid), 64'd0);
        else chk("w8_latency", 64'(cyc), 64'(q8[0].acc_cyc + 8));
      end
      if (b8.out_valid && q8.size() > 0) begin
        chk("w8_product", 64'(b8.out_product), q8[0].prod);
        if (b8.out_ready) begin
          last8 = q8[0].prod;
          void'(q8.pop_front());
          idle_chk8 = 1'b1;
        end
      end
      prev_v8 = b8.out_valid;
    end
  end

  bit          prev_v16, idle_chk16;
  logic [63:0] last16;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v16   = 1'b0;
      idle_chk16 = 1'b0;
    end else begin
      if (idle_chk16) begin
        chk("w16_in_ready_after_handshake", 64'(b16.in_ready), 64'd1);
        chk("w16_product_held", 64'(b16.out_product), last16);
        idle_chk16 = 1'b0;
      end
      if (b16.out_valid && !prev_v16) begin
        if (q16.size() == 0) chk("w16_unexpected_out_valid", 64'(b16.out_valid), 64'd0);
        else chk("w16_latency", 64'(cyc), 64'(q16[0].acc_cyc + 16));
      end
      if (b16.out_valid && q16.size() > 0) begin
        chk("w16_product", 64'(b16.out_product), q16[0].prod);
        if (b16.out_ready) begin
          last16 = q16[0].prod;
          void'(q16.pop_front());
          idle_chk16 = 1'b1;
        end
      end
      prev_v16 = b16.out_valid;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 2000) begin
      step();
      n++;
    end
    chk("drain_q8_empty", 64'(q8.size()), 64'd0);
    chk("drain_q16_empty", 64'(q16.size()), 64'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    b8.in_valid = 1'b0;  b8.in_a = '0;  b8.in_b = '0;  b8.in_signed = 1'b0;  b8.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_signed = 1'b0; b16.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 64'(b8.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
    chk("rst_busy", 64'(b8.busy), 64'd0);
    chk("rst_product", 64'(b8.out_product), 64'd0);
    chk("rst16_product", 64'(b16.out_product), 64'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Directed corner products at WIDTH 8.
    issue(8, 32'hFF, 32'hFF, 1'b0, 1'b1);
    drain();
    chk("const_255x255", ref_mul(64'hFF, 64'hFF, 8, 1'b0), 64'hFE01);
    issue(8, 32'h80, 32'h80, 1'b1, 1'b1);
    issue(8, 32'h80, 32'h7F, 1'b1, 1'b1);
    issue(8, 32'hFF, 32'h01, 1'b1, 1'b1);
    issue(8, 32'h80, 32'h02, 1'b0, 1'b1);
    issue(8, 32'h00, 32'd200, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 20; i++) begin
      issue(8, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();

    // Backpressure with junk traffic on the input side.
    b8.out_ready = 1'b0;
    issue(8, 32'hA5, 32'h3C, 1'b1, 1'b1);
    n = 0;
    while (!b8.out_valid && n < 50) begin
      b8.in_valid = 1'($urandom); b8.in_a = 8'($urandom); b8.in_b = 8'($urandom);
      step();
      n++;
    end
    chk("bp_out_valid_reached", 64'(b8.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      b8.in_valid = 1'($urandom); b8.in_a = 8'($urandom); b8.in_b = 8'($urandom);
      step();
      chk("bp_in_ready_low", 64'(b8.in_ready), 64'd0);
      chk("bp_busy_high", 64'(b8.busy), 64'd1);
      chk("bp_out_valid_held", 64'(b8.out_valid), 64'd1);
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    drain();

    // Reset mid-operation discards the transaction.
    issue(8, 32'd9, 32'd9, 1'b0, 1'b0);
    chk("mid_busy_high", 64'(b8.busy), 64'd1);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(b8.in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(b8.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(b8.busy), 64'd0);
    chk("mid_rst_product", 64'(b8.out_product), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (12) begin
      step();
      chk("post_rst_no_valid", 64'(b8.out_valid), 64'd0);
    end
    issue(8, 32'd3, 32'd4, 1'b0, 1'b1);
    drain();

    // WIDTH 16 instance.
    issue(16, 32'hFFFF, 32'hFFFF, 1'b0, 1'b1);
    issue(16, 32'h8000, 32'h8000, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      issue(16, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();
    chk("const_w16_max", ref_mul(64'hFFFF, 64'hFFFF, 16, 1'b0), 64'hFFFE0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
